fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised instruction-fetch front end for the 64-bit LEGv8-style processor. It replaces the bare PC register with a decoupled fetch stage: it owns the program counter, issues in-order requests to a variable-latency instruction memory, buffers returned instructions in a prefetch queue, and hands them to decode through a valid/ready handshake. Branch redirects are taken from execute (BrTaken/UncondBr semantics); the unit computes the target itself, flushes queued instructions and drops stale memory responses.

## Interface
- ADDR_W, 64, PC/address width
- INSTR_W, 32, instruction width
- DEPTH, 4, prefetch queue entries and maximum outstanding requests; power of 2, >= 2
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address (current PC)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, >= 1 cycle after acceptance
- imem_rdata  in  INSTR_W  response instruction
- instr_valid  out  1  queue head valid
- instr  out  INSTR_W  queue head instruction
- instr_pc  out  ADDR_W  address of queue head
- instr_ready  in  1  decode consumes head
- br_taken  in  1  redirect request from execute
- br_uncond  in  1  1 = B-format offset, 0 = CB-format offset
- br_pc  in  ADDR_W  address of the branching instruction
- br_instr  in  32  branching instruction word

## Operation
- Request accepted when imem_req & imem_ready; PC <= PC + 4 (modulo 2^ADDR_W).
- imem_req = !reset & (queue_count + outstanding < DEPTH). Credits guarantee queue never overflows.
- outstanding: +1 on accept, -1 on every imem_rvalid (kept or dropped).
- Response kept unless drop_cnt > 0; kept response written to tail with its PC (PC FIFO tracked alongside outstanding requests). Dropped response decrements drop_cnt.
- Head transfer when instr_valid & instr_ready; head advances.
- Target: br_uncond ? br_pc + (sext(br_instr[25:0]) << 2) : br_pc + (sext(br_instr[23:5]) << 2), truncated to ADDR_W.
- Redirect (br_taken=1): PC <= target; queue emptied; drop_cnt <= outstanding_next (outstanding after this cycle's accept and response). Request accepted in the redirect cycle uses the old PC and is dropped.
- Simultaneous events in redirect cycle: head transfer with instr_ready=1 completes normally (decode squashes it); response arriving that cycle is discarded; redirect overrides PC increment.
- br_taken while drop_cnt > 0: drop_cnt recomputed as above (all in-flight responses dropped).
- Reset: PC=RESET_PC, queue empty, outstanding=0, drop_cnt=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0. Reset mid-operation abandons in-flight requests; responses arriving after reset with outstanding=0 are ignored.

## Timing
- Reset deasserted at cycle 0 -> imem_req=1, imem_addr=RESET_PC in cycle 0.
- Response at cycle M -> instr_valid=1 at M+1 (registered queue).
- Redirect at cycle N -> imem_addr=target with imem_req at N+1; earliest target instruction at decode N+3 with one-cycle memory.
- Steady state with one-cycle memory and instr_ready=1: one instruction per cycle.
- instr/instr_pc stable while instr_valid & !instr_ready and no redirect.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32-bit, count of head transfers), perf_flushed (32-bit, count of redirects), perf_dropped (32-bit, count of dropped responses); all reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; functional behaviour identical.

## Test plan
- Reset, one-cycle memory, instr_ready=1: addresses 0,4,8,... each cycle; instr_pc follows with 2-cycle lag; no bubbles after fill.
- instr_ready=0 for 10 cycles, DEPTH=4: exactly 4 requests accepted, imem_req then 0; head held at PC 0 until ready rises.
- Three-cycle memory latency: at most DEPTH requests outstanding; in-order delivery of PCs 0..0x3C with no loss.
- br_taken with br_pc=0x100, br_uncond=1, br_instr[25:0]=0x3FFFFFE (-2): next imem_addr=0xF8; queue cleared; 3 in-flight responses dropped; first delivered instr_pc=0xF8.
- br_uncond=0, br_instr[23:5]=0x10, br_pc=0x40, redirect while a response arrives and head transfers same cycle: head delivered, response discarded, next fetch 0x80.
- Reset asserted with 2 outstanding; responses arrive after reset: ignored, instr_valid stays 0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// fetch_queue_unit : decoupled fetch stage (PC, in-order imem requests, prefetch
//                    queue, branch redirect). FETCH_PERF_EN adds perf counters.
// Revision         : 1.0
// ============================================================================
module fetch_queue_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               br_taken,
  input  logic               br_uncond,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [31:0]        br_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int                c_PTR_W   = $clog2(DEPTH);
  localparam int                c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_CNT_W:0]  c_DEPTH_U = (c_CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_q_instr [DEPTH];
  logic [ADDR_W-1:0]  r_q_pc    [DEPTH];
  logic [c_PTR_W-1:0] r_q_head, r_q_tail;
  logic [c_CNT_W-1:0] r_q_count;
  logic [ADDR_W-1:0]  r_pf_pc   [DEPTH];
  logic [c_PTR_W-1:0] r_pf_head, r_pf_tail;
  logic [c_CNT_W-1:0] r_outstanding, r_drop_cnt;

  logic               w_accept, w_resp, w_keep, w_pop;
  logic [c_CNT_W:0]   w_used;
  logic [c_CNT_W-1:0] w_out_next, w_q_count_next;
  logic [ADDR_W-1:0]  w_off_b, w_off_cb, w_target;
  logic               w_unused;

  // Credits: queue slots plus in-flight requests never exceed DEPTH.
  assign w_used    = {1'b0, r_q_count} + {1'b0, r_outstanding};
  assign imem_req  = !reset && (w_used < c_DEPTH_U);
  assign imem_addr = r_pc;

  assign w_accept = imem_req && imem_ready;
  assign w_resp   = imem_rvalid && (r_outstanding != '0);
  assign w_keep   = w_resp && (r_drop_cnt == '0) && !br_taken && !reset;
  assign w_pop    = instr_valid && instr_ready;

  assign instr_valid = (r_q_count != '0);
  assign instr       = instr_valid ? r_q_instr[r_q_head] : '0;
  assign instr_pc    = instr_valid ? r_q_pc[r_q_head]    : '0;

  assign w_off_b  = {{(ADDR_W-28){br_instr[25]}}, br_instr[25:0], 2'b00};
  assign w_off_cb = {{(ADDR_W-21){br_instr[23]}}, br_instr[23:5], 2'b00};
  assign w_target = br_pc + (br_uncond ? w_off_b : w_off_cb);
  assign w_unused = ^br_instr[31:26];

  always_comb begin
    w_out_next = r_outstanding;
    case ({w_accept, w_resp})
      2'b10:   w_out_next = r_outstanding + c_CNT_W'(1);
      2'b01:   w_out_next = r_outstanding - c_CNT_W'(1);
      default: ;
    endcase
  end

  always_comb begin
    w_q_count_next = r_q_count;
    case ({w_keep, w_pop})
      2'b10:   w_q_count_next = r_q_count + c_CNT_W'(1);
      2'b01:   w_q_count_next = r_q_count - c_CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_q_head      <= '0;
      r_q_tail      <= '0;
      r_q_count     <= '0;
      r_pf_head     <= '0;
      r_pf_tail     <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_accept) r_pf_tail <= r_pf_tail + c_PTR_W'(1);
      if (w_resp)   r_pf_head <= r_pf_head + c_PTR_W'(1);
      if (br_taken) begin
        // Everything still in flight, including this cycle's accept, is stale.
        r_pc       <= w_target;
        r_q_head   <= '0;
        r_q_tail   <= '0;
        r_q_count  <= '0;
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_accept) r_pc     <= r_pc + c_PC_STEP;
        if (w_keep)   r_q_tail <= r_q_tail + c_PTR_W'(1);
        if (w_pop)    r_q_head <= r_q_head + c_PTR_W'(1);
        r_q_count <= w_q_count_next;
        if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pf_pc[r_pf_tail] <= r_pc;
    if (w_keep) begin
      r_q_instr[r_q_tail] <= imem_rdata;
      r_q_pc[r_q_tail]    <= r_pf_pc[r_pf_head];
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_flushed, r_perf_dropped;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_dropped <= '0;
    end else begin
      if (w_pop)             r_perf_fetched <= r_perf_fetched + 32'd1;
      if (br_taken)          r_perf_flushed <= r_perf_flushed + 32'd1;
      if (w_resp && !w_keep) r_perf_dropped <= r_perf_dropped + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
  assign perf_dropped = r_perf_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// Bench for fetch_queue_unit: program-order PC stream model plus an in-order
// variable-latency memory, with directed scenarios followed by random traffic.
module tb_fetch_queue_unit;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_req, imem_ready, imem_rvalid;
  logic        instr_valid, instr_ready, br_taken, br_uncond;
  logic [63:0] imem_addr, instr_pc, br_pc;
  logic [31:0] imem_rdata, instr, br_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_dropped;
`endif

  fetch_queue_unit #(
    .ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .br_taken(br_taken), .br_uncond(br_uncond), .br_pc(br_pc), .br_instr(br_instr)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_dropped(perf_dropped)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
    bit          live;
    bit          stale;
  } mreq_t;

  mreq_t       mq[$];     // memory's in-order pending requests
  logic [63:0] exp_q[$];  // PCs decode should see, in order
  logic [63:0] ref_pc;
  int          cyc, last_due;
  int          n_checks, n_fail;

  bit          d_reset, d_mem_ready, d_instr_ready, d_br, d_unc;
  logic [63:0] d_bpc;
  logic [31:0] d_binstr;
  int          lat_lo, lat_hi;

  int          n_accept, n_deliver, n_drop_resp, max_out, killed;
  logic [63:0] first_after_br;
  bit          watch_br, seen_after_br;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
  endfunction

  function automatic logic [63:0] br_target(input bit unc, input logic [63:0] pc,
                                            input logic [31:0] w);
    longint off;
    if (unc) off = longint'($signed(w[25:0]));
    else     off = longint'($signed(w[23:5]));
    return pc + 64'(off * 4);
  endfunction

  task automatic step();
    bit    resp, accept, xfer, exp_req, exp_valid, stale_pend;
    int    outc, lat, due;
    mreq_t e;
    @(negedge clk);
    cyc++;
    stale_pend = 0;
    outc       = 0;
    foreach (mq[i]) begin
      if (mq[i].stale) stale_pend = 1;
      else             outc++;
    end
    reset       = d_reset;
    instr_ready = d_reset ? 1'b0 : d_instr_ready;
    br_taken    = d_reset ? 1'b0 : d_br;
    br_uncond   = d_unc;
    br_pc       = d_bpc;
    br_instr    = d_binstr;
    imem_ready  = d_mem_ready && !stale_pend;
    resp        = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rvalid = resp;
    imem_rdata  = resp ? mem_word(mq[0].addr) : $urandom();
    #1;
    exp_req   = !d_reset && ((exp_q.size() + outc) < DEPTH);
    exp_valid = (exp_q.size() != 0);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, ref_pc);
    check("instr_valid", instr_valid, exp_valid);
    if (exp_valid) begin
      check("instr_pc", instr_pc, exp_q[0]);
      check("instr", instr, mem_word(exp_q[0]));
    end
    accept = exp_req && imem_ready;
    xfer   = exp_valid && instr_ready;
    if (outc > max_out) max_out = outc;
    if (accept) n_accept++;
    if (xfer) begin
      n_deliver++;
      if (watch_br && !seen_after_br) begin
        first_after_br = exp_q[0];
        seen_after_br  = 1;
      end
    end
    if (resp) e = mq.pop_front();
    if (d_reset) begin
      exp_q.delete();
      foreach (mq[i]) begin
        mq[i].stale = 1;
        mq[i].live  = 0;
      end
      ref_pc = RESET_PC;
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (resp && !e.stale) begin
        if (e.live) exp_q.push_back(e.addr);
        else        n_drop_resp++;
      end
      if (accept) begin
        lat = $urandom_range(lat_hi, lat_lo);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        mq.push_back('{addr: ref_pc, due: due, live: 1'b1, stale: 1'b0});
        last_due = due;
      end
      if (br_taken) begin
        exp_q.delete();
        foreach (mq[i]) mq[i].live = 0;
        ref_pc = br_target(d_unc, d_bpc, d_binstr);
      end else if (accept) begin
        ref_pc = ref_pc + 64'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic restart(input int lat);
    d_reset = 1; d_br = 0; lat_lo = lat; lat_hi = lat;
    step();
    d_reset = 0;
    n_accept = 0; n_deliver = 0; max_out = 0; n_drop_resp = 0;
    watch_br = 0; seen_after_br = 0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; last_due = 0; ref_pc = RESET_PC;
    reset = 1; imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    instr_ready = 0; br_taken = 0; br_uncond = 0; br_pc = '0; br_instr = '0;
    d_reset = 0; d_mem_ready = 1; d_instr_ready = 1; d_br = 0; d_unc = 0;
    d_bpc = '0; d_binstr = '0; lat_lo = 1; lat_hi = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", imem_req, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);

    // One-cycle memory, decode always ready: one instruction per cycle.
    restart(1);
    run(20);
    check("a_accepts", n_accept, 20);
    check("a_delivered", n_deliver, 18);

    // Decode stalled: credits cap the requests at DEPTH.
    restart(1);
    d_instr_ready = 0;
    run(10);
    check("b_accepts", n_accept, DEPTH);
    check("b_req_idle", imem_req, 0);
    check("b_head_valid", instr_valid, 1);
    check("b_head_pc", instr_pc, 64'h0);
    d_instr_ready = 1;
    run(10);

    // Three-cycle memory, then an unconditional redirect backwards.
    restart(3);
    run(40);
    check("c_max_out_le_depth", max_out <= DEPTH, 1);
    check("c_delivered_ge16", n_deliver >= 16, 1);
    d_br = 1; d_unc = 1; d_bpc = 64'h100; d_binstr = 32'h03FF_FFFE;
    step();
    d_br = 0;
    killed = mq.size(); n_drop_resp = 0; watch_br = 1;
    step();
    check("d_redirect_addr", imem_addr, 64'hF8);
    check("d_queue_cleared", instr_valid, 0);
    run(12);
    check("d_first_pc", first_after_br, 64'hF8);
    check("d_dropped", n_drop_resp, killed);

    // CB-format redirect while a response arrives and the head transfers.
    restart(1);
    run(8);
    d_br = 1; d_unc = 0; d_bpc = 64'h40; d_binstr = 32'h0000_0200;
    n_deliver = 0;
    step();
    d_br = 0;
    check("e_head_delivered", n_deliver, 1);
    watch_br = 1;
    step();
    check("e_redirect_addr", imem_addr, 64'h80);
    run(6);
    check("e_first_pc", first_after_br, 64'h80);

    // Reset with two requests in flight; their responses must be ignored.
    restart(3);
    run(2);
    d_reset = 1;
    step();
    d_reset = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("f_valid_after_reset", instr_valid, 0);
    end
    run(10);

    // Random traffic with redirects, stalls, variable latency and resets.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      d_reset       = ($urandom_range(299, 0) == 0);
      d_mem_ready   = ($urandom_range(3, 0) != 0);
      d_instr_ready = ($urandom_range(3, 0) != 0);
      d_br          = ($urandom_range(15, 0) == 0);
      d_unc         = $urandom_range(1, 0) == 1;
      d_bpc         = {32'h0, $urandom()} & 64'h0000_0000_00FF_FFFC;
      d_binstr      = $urandom();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
